// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Number of words the skid ring can hold; also the read credit limit.
  localparam int SKID_DEPTH = 3;

  // Advance a ring pointer, wrapping modulo SKID_DEPTH.
  function automatic logic [1:0] ring_next(input logic [1:0] ptr);
    logic [1:0] nxt;
    case (ptr)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry ring buffer that absorbs FIFO read data while the consumer stalls.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [FIFO_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic [FIFO_WIDTH-1:0] head_o
);

  logic [FIFO_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  // Next pointer and occupancy values; a simultaneous push and pop keeps occ.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      wr_ptr_d = ring_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ring_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Ring storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= {FIFO_WIDTH{1'b0}};
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts the FIFO pull interface into a valid/ready stream with burst marking.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_underflow
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  rd_state_e         state_q, state_d;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [1:0]            occ_s;
  logic [FIFO_WIDTH-1:0] head_s;
  logic [2:0]            used_s;
  logic                  pop_s;
  logic                  rd_en_s;

  fifo_rd_skid #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop_s),
    .occ_o       (occ_s),
    .head_o      (head_s)
  );

  // Credit check counts the word already requested but not yet captured, so the
  // ring can never overflow; the strobe never depends on m_ready.
  assign used_s  = {1'b0, occ_s} + {2'b00, inflight_q};
  assign rd_en_s = (state_q == RUN) && !fifo_empty && (used_s < 3'(SKID_DEPTH)) && !rst;
  assign pop_s   = m_valid && m_ready;

  // FSM next state: fetching only in RUN; DRAIN waits for the ring and the
  // in-flight word to empty before going idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if ((occ_s == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat position within the burst advances per accepted word and survives pauses.
  always_comb begin
    beat_d = beat_q;
    if (pop_s) begin
      if (beat_q == BEAT_MAX) begin
        beat_d = {BEAT_W{1'b0}};
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Underflow reported by the FIFO is latched until reset.
  always_comb begin
    err_d = err_q;
    if (fifo_underflow) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      beat_q     <= {BEAT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en_s;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign fifo_rd_en    = rd_en_s;
  assign m_valid       = (occ_s != 2'd0);
  assign m_data        = head_s;
  assign m_last        = m_valid && (beat_q == BEAT_MAX);
  assign busy          = (state_q != IDLE);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench for fifo_rd_adapter: a queue-based FIFO model feeds the DUT,
// the expected stream is the FIFO contents in order with last on every
// BURST_LEN-th word since reset.
module tb_fifo_rd_adapter;

  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_ready = 1'b0;
  logic         busy;
  logic         err_underflow;

  fifo_rd_adapter #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model and shared state ----------------
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int cyc      = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) cyc <= cyc + 1;

  // Registered read data: word appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (fifo_rd_en && (fifo_q.size() > 0)) begin
      fifo_dout <= fifo_q.pop_front();
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // ---------------- monitor ----------------
  int delivered_n = 0;
  int out_n = 0;
  int max_out = 0;
  int reads_since_rst = 0;
  int total_reads = 0;
  int total_pops = 0;
  int rd_empty_viol = 0;
  int rst_rd_viol = 0;
  int first_rd_cyc = -1;
  int first_v_cyc = -1;
  int c0 = -1;
  int c7 = -1;
  int last_pop_cyc = 0;
  bit hold_valid = 1'b0;
  logic [W-1:0] hold_data = '0;
  logic [W-1:0] exp_word;
  bit exp_last;

  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rd_en) rst_rd_viol++;
      delivered_n = 0; out_n = 0; reads_since_rst = 0;
      first_rd_cyc = -1; first_v_cyc = -1; hold_valid = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) rd_empty_viol++;
      if (fifo_rd_en) begin
        if (reads_since_rst == 0) first_rd_cyc = cyc;
        reads_since_rst++; total_reads++; out_n++;
      end
      if (out_n > max_out) max_out = out_n;
      if (m_valid && (first_v_cyc < 0)) first_v_cyc = cyc;
      if (hold_valid) begin
        check(m_valid == 1'b1, "hold_valid", m_valid, 1);
        check(m_data == hold_data, "hold_data", m_data, hold_data);
      end
      if (!m_valid && m_last) check(1'b0, "last_without_valid", m_last, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", m_data, 0);
        end else begin
          exp_word = exp_q.pop_front();
          exp_last = ((delivered_n % BL) == (BL - 1));
          check(m_data == exp_word, "data", m_data, exp_word);
          check(m_last == exp_last, "last", m_last, exp_last);
        end
        if (delivered_n == 0) c0 = cyc;
        if (delivered_n == 7) c7 = cyc;
        delivered_n++; total_pops++; out_n--;
        last_pop_cyc = cyc;
      end
      hold_valid = m_valid && !m_ready;
      hold_data  = m_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    push_cnt = pop_cnt;
  endtask

  task automatic load(input int n, input bit seq, input int base);
    logic [W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = seq ? W'(base + i) : W'($urandom);
      fifo_q.push_back(v);
      exp_q.push_back(v);
      push_cnt++;
    end
  endtask

  task automatic wait_exp_empty(input int bound, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0) && (i < bound)) begin
      tick();
      i++;
    end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int i;
    i = 0;
    while (busy && (i < bound)) begin
      tick();
      i++;
    end
    check(busy == 1'b0, name, busy, 0);
  endtask

  // ---------------- test sequence ----------------
  int snap_reads;
  int snap_pops;
  int k;

  initial begin
    // Reset with en high and a non-empty FIFO.
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    flush();
    load(8, 1'b1, 1);
    tick(); tick();
    check(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
    check(m_data == '0, "rst_m_data", m_data, 0);
    check(m_last == 1'b0, "rst_m_last", m_last, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(err_underflow == 1'b0, "rst_err", err_underflow, 0);
    check(fifo_rd_en == 1'b0, "rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;

    // Streaming 0x0001..0x0008.
    wait_exp_empty(40, "stream_done");
    check((first_v_cyc - first_rd_cyc) == 2, "first_latency", first_v_cyc - first_rd_cyc, 2);
    check((c7 - c0) == 7, "back_to_back", c7 - c0, 7);

    // Backpressure during a stream.
    load(12, 1'b0, 0);
    tick(); tick(); tick();
    m_ready = 1'b0;
    repeat (6) tick();
    m_ready = 1'b1;
    wait_exp_empty(60, "backpressure_done");

    // Drain with a full buffer and a word in flight.
    en = 1'b0;
    wait_idle(20, "pre_drain_idle");
    m_ready = 1'b0;
    load(8, 1'b1, 16'h0100);
    tick();
    en = 1'b1;
    k = 0;
    while (!fifo_rd_en && (k < 10)) begin
      tick();
      k++;
    end
    check(fifo_rd_en == 1'b1, "drain_first_rd", fifo_rd_en, 1);
    tick(); tick(); tick();
    check(out_n == 3, "drain_outstanding", out_n, 3);
    en = 1'b0;
    snap_reads = total_reads;
    snap_pops  = total_pops;
    tick(); tick();
    check(busy == 1'b1, "drain_busy", busy, 1);
    m_ready = 1'b1;
    wait_idle(20, "drain_idle");
    check((total_reads - snap_reads) == 0, "drain_no_reads", total_reads - snap_reads, 0);
    check((total_pops - snap_pops) == 3, "drain_words", total_pops - snap_pops, 3);
    check((cyc - last_pop_cyc) <= 2, "drain_busy_fall", cyc - last_pop_cyc, 2);

    // Sticky underflow flag.
    check(err_underflow == 1'b0, "err_before", err_underflow, 0);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    check(err_underflow == 1'b1, "err_set", err_underflow, 1);
    repeat (5) tick();
    check(err_underflow == 1'b1, "err_held", err_underflow, 1);

    // Reset mid-burst with words buffered.
    load(10, 1'b0, 0);
    en = 1'b1;
    snap_pops = total_pops;
    k = 0;
    while (((total_pops - snap_pops) < 2) && (k < 20)) begin
      tick();
      k++;
    end
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    flush();
    tick();
    check(m_valid == 1'b0, "midrst_m_valid", m_valid, 0);
    check(m_last == 1'b0, "midrst_m_last", m_last, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(err_underflow == 1'b0, "midrst_err", err_underflow, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    load(4, 1'b1, 16'h0A00);
    wait_exp_empty(40, "post_rst_burst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) load(1, 1'b0, 0);
      tick();
    end
    en = 1'b1;
    m_ready = 1'b1;
    wait_exp_empty(200, "random_done");

    check(rd_empty_viol == 0, "rd_when_empty", rd_empty_viol, 0);
    check(rst_rd_viol == 0, "rd_during_rst", rst_rd_viol, 0);
    check(max_out <= 3, "max_outstanding", max_out, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
